// File: rtl/cache_stats_readout_sequencer.sv
// Host-side reader for the cache performance controller register window: walks an index
// range, waits out the controller's read latency and streams each returned word on valid/ready.
module cache_stats_readout_sequencer #(
    parameter int READ_LATENCY   = 2,
    parameter bit FREEZE_ON_READ = 1'b1,
    parameter int IDX_W          = 5
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [IDX_W-1:0] first_idx_i,
    input  logic [IDX_W-1:0] last_idx_i,
    input  logic [1:0]       record_sel_i,
    input  logic             count_en_i,
    output logic [31:0]      comm_o,
    output logic [1:0]       select_data_record_o,
    input  logic [31:0]      comm_i,
    output logic [31:0]      data_o,
    output logic [IDX_W-1:0] tag_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W:0]   words_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_PUSH,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(READ_LATENCY - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] cur_reg;
    logic [IDX_W-1:0] last_reg;
    logic [1:0]       sel_reg;
    logic [3:0]       wait_reg;
    logic [IDX_W:0]   words_reg;
    logic [IDX_W:0]   words_out_reg;
    logic [31:0]      data_reg;
    logic [IDX_W-1:0] tag_reg;
    logic             valid_reg;
    logic             reading;
    logic             handshake;

    // The index stays on the bus from ISSUE until the word is handed off.
    assign reading   = (state_reg == S_ISSUE) || (state_reg == S_WAIT) ||
                       (state_reg == S_CAPTURE) || (state_reg == S_PUSH);
    assign handshake = (state_reg == S_PUSH) && valid_reg && ready_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    state_next = (first_idx_i > last_idx_i) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE:   state_next = S_WAIT;
            S_WAIT:    state_next = (wait_reg == 4'd0) ? S_CAPTURE : S_WAIT;
            S_CAPTURE: state_next = S_PUSH;
            S_PUSH: begin
                if (handshake) begin
                    state_next = (cur_reg == last_reg) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        comm_o               = '0;
        comm_o[IDX_W-1:0]    = reading ? cur_reg : '0;
        // Freezing keeps lo/hi halves of 64-bit counters coherent across the dump.
        comm_o[24]           = ((state_reg == S_IDLE) || !FREEZE_ON_READ) ? count_en_i : 1'b0;
        select_data_record_o = (state_reg == S_IDLE) ? 2'b00 : sel_reg;
        busy_o               = (state_reg != S_IDLE);
        done_o               = (state_reg == S_DONE);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg     <= S_IDLE;
            cur_reg       <= '0;
            last_reg      <= '0;
            sel_reg       <= 2'b00;
            wait_reg      <= 4'd0;
            words_reg     <= '0;
            words_out_reg <= '0;
            data_reg      <= '0;
            tag_reg       <= '0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        cur_reg   <= first_idx_i;
                        last_reg  <= last_idx_i;
                        sel_reg   <= record_sel_i;
                        words_reg <= '0;
                    end
                end
                S_ISSUE: wait_reg <= WAIT_LOAD;
                S_WAIT: begin
                    if (wait_reg != 4'd0) begin
                        wait_reg <= wait_reg - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    data_reg  <= comm_i;
                    tag_reg   <= cur_reg;
                    valid_reg <= 1'b1;
                    words_reg <= words_reg + 1'b1;
                end
                S_PUSH: begin
                    // Comparing against last (not a wrapped successor) lets the top index terminate.
                    if (handshake) begin
                        valid_reg <= 1'b0;
                        if (cur_reg != last_reg) begin
                            cur_reg <= cur_reg + 1'b1;
                        end
                    end
                end
                S_DONE: words_out_reg <= words_reg;
                default: ;
            endcase
        end
    end

    assign data_o  = data_reg;
    assign tag_o   = tag_reg;
    assign valid_o = valid_reg;
    assign words_o = words_out_reg;

endmodule
